// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: single-port AHB-Lite memory slave with a programmable number of
// wait states per data phase and byte/halfword/word write lanes.
// Optional feature macro AHB_SLV_ERR_RESP_EN: when defined, accepted transfers to
// byte addresses >= DEPTH*4 get the two-cycle ERROR response and never touch memory.
// When undefined, addresses alias modulo DEPTH*4 and hresp is tied low.
module ahb_slave_mem #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0,
    parameter int IDX_W       = $clog2(DEPTH)
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

`ifdef AHB_SLV_ERR_RESP_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_t;
`endif

    // Counter reload value: a WAIT phase lasts WAIT_CYCLES cycles, counting down to 0.
    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t           state;
    state_t           next_state;
    logic [2:0]       wait_cnt;
    logic [IDX_W+1:0] addr_q;
    logic             write_q;
    logic [2:0]       size_q;
    logic [31:0]      mem [DEPTH];
    logic             can_accept;
    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       byte_en;

`ifdef AHB_SLV_ERR_RESP_EN
    logic out_of_range;
    logic unused_inputs;

    assign out_of_range  = |haddr[31:IDX_W+2];
    assign unused_inputs = ^{htrans[0], hburst, hprot, hmastlock};
`else
    logic unused_inputs;

    assign unused_inputs = ^{htrans[0], hburst, hprot, hmastlock, haddr[31:IDX_W+2]};
`endif

    assign accept   = hsel & hready & htrans[1] & can_accept;
    assign word_idx = addr_q[IDX_W+1:2];

    // A new address phase can only be taken while this slave is not stalling the bus.
    always_comb begin
        can_accept = 1'b1;
        if (state == ST_WAIT) begin
            can_accept = 1'b0;
        end
`ifdef AHB_SLV_ERR_RESP_EN
        if (state == ST_ERR1) begin
            can_accept = 1'b0;
        end
`endif
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: IDLE, DATA and ERR2 all behave alike and may take a pipelined accept.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    next_state = ST_DATA;
                end
            end
`ifdef AHB_SLV_ERR_RESP_EN
            ST_ERR1: next_state = ST_ERR2;
`endif
            default: begin
                if (!accept) begin
                    next_state = ST_IDLE;
`ifdef AHB_SLV_ERR_RESP_EN
                end else if (out_of_range) begin
                    next_state = ST_ERR1;
`endif
                end else if (WAIT_CYCLES > 0) begin
                    next_state = ST_WAIT;
                end else begin
                    next_state = ST_DATA;
                end
            end
        endcase
    end

    // Bus response outputs; read data is only driven in the data phase of a read.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        unique case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_DATA: begin
                if (!write_q) begin
                    hrdata = mem[word_idx];
                end
            end
`ifdef AHB_SLV_ERR_RESP_EN
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
`endif
            default: ;
        endcase
    end

    // Wait-state counter: loaded on every accept, counts down while stalling.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wait_cnt <= 3'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Address-phase control captured for use in the following data phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else if (accept) begin
            addr_q  <= haddr[IDX_W+1:0];
            write_q <= hwrite;
            size_q  <= hsize;
        end
    end

    // Byte lanes touched by a write; sizes above word are treated as word.
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            3'd0:    byte_en[addr_q[1:0]] = 1'b1;
            3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Memory array: write commits at the edge that closes the write data phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == ST_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= hwdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: drives two slave instances (zero and three wait states) with
// directed and random AHB-Lite transfers and compares every response against a
// transaction-level memory model.
module tb_ahb_slave_mem;

    localparam int DEPTH = 16;

`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        write;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [31:0] wdata;
    } xfer_t;

    logic        hclk;
    logic        hreset_v    [2];
    logic        hsel_v      [2];
    logic [31:0] haddr_v     [2];
    logic        hwrite_v    [2];
    logic [2:0]  hsize_v     [2];
    logic [2:0]  hburst_v    [2];
    logic [3:0]  hprot_v     [2];
    logic [1:0]  htrans_v    [2];
    logic        hmastlock_v [2];
    logic        hready_v    [2];
    logic [31:0] hwdata_v    [2];
    logic        hreadyout_v [2];
    logic        hresp_v     [2];
    logic [31:0] hrdata_v    [2];

    bit [31:0] model_mem [2][DEPTH];
    xfer_t     q[$];
    int        error_count = 0;
    int        check_count = 0;

    assign hready_v[0] = hreadyout_v[0];
    assign hready_v[1] = hreadyout_v[1];

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset_v[0]), .hsel(hsel_v[0]), .haddr(haddr_v[0]),
        .hwrite(hwrite_v[0]), .hsize(hsize_v[0]), .hburst(hburst_v[0]), .hprot(hprot_v[0]),
        .htrans(htrans_v[0]), .hmastlock(hmastlock_v[0]), .hready(hready_v[0]),
        .hwdata(hwdata_v[0]), .hreadyout(hreadyout_v[0]), .hresp(hresp_v[0]),
        .hrdata(hrdata_v[0])
    );

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .hclk(hclk), .hreset(hreset_v[1]), .hsel(hsel_v[1]), .haddr(haddr_v[1]),
        .hwrite(hwrite_v[1]), .hsize(hsize_v[1]), .hburst(hburst_v[1]), .hprot(hprot_v[1]),
        .htrans(htrans_v[1]), .hmastlock(hmastlock_v[1]), .hready(hready_v[1]),
        .hwdata(hwdata_v[1]), .hreadyout(hreadyout_v[1]), .hresp(hresp_v[1]),
        .hrdata(hrdata_v[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic int waitsOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic string tag(input int d, input string s);
        return $sformatf("d%0d_%s", d, s);
    endfunction

    function automatic bit isErr(input bit [31:0] a);
        return ERR_EN && (a >= 32'(DEPTH * 4));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, observed, expected, $time);
        end
    endtask

    task automatic addXfer(input bit sel, input bit [1:0] trans, input bit write,
                           input bit [31:0] addr, input bit [2:0] size, input bit [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.write = write;
        x.addr = addr; x.size = size; x.wdata = wdata;
        q.push_back(x);
    endtask

    task automatic driveAddr(input int d, input xfer_t x);
        hsel_v[d]      = x.sel;
        htrans_v[d]    = x.trans;
        haddr_v[d]     = x.addr;
        hwrite_v[d]    = x.write;
        hsize_v[d]     = x.size;
        hburst_v[d]    = 3'($urandom);
        hprot_v[d]     = 4'($urandom);
        hmastlock_v[d] = 1'($urandom);
    endtask

    task automatic driveIdle(input int d);
        hsel_v[d]   = 1'b0;
        htrans_v[d] = 2'd0;
        hwrite_v[d] = 1'b0;
        haddr_v[d]  = 32'h0;
        hsize_v[d]  = 3'd0;
    endtask

    // Final cycle of an accepted transfer: check response, then apply the write to the model.
    task automatic completeXfer(input int d, input xfer_t x, input int low_cnt,
                                input logic rs, input logic [31:0] rd);
        bit        err;
        int        w;
        bit [31:0] mask;
        err = isErr(x.addr);
        w   = int'((x.addr / 4) % DEPTH);
        checkOutput(tag(d, "low_cycles"), 32'(low_cnt), 32'(err ? 1 : waitsOf(d)));
        checkOutput(tag(d, "done_resp"), 32'(rs), 32'(err));
        if (!err && !x.write) begin
            checkOutput(tag(d, "read_data"), rd, model_mem[d][w]);
        end else begin
            checkOutput(tag(d, "done_rdata"), rd, 32'h0);
        end
        if (!err && x.write) begin
            if (x.size == 3'd0) begin
                mask = 32'hFF << (8 * (x.addr % 4));
            end else if (x.size == 3'd1) begin
                mask = x.addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end else begin
                mask = 32'hFFFF_FFFF;
            end
            model_mem[d][w] = (model_mem[d][w] & ~mask) | (x.wdata & mask);
        end
    endtask

    // Plays the queued transfers back-to-back on instance d as a pipelined AHB master.
    task automatic applyStimulus(input int d);
        int          idx = 0;
        int          inflight = -1;
        int          low_cnt = 0;
        int          cycles = 0;
        bit          new_in = 1'b0;
        logic        ro;
        logic        rs;
        logic [31:0] rd;
        while ((idx < q.size() || inflight >= 0) && cycles < 2000) begin
            @(negedge hclk);
            cycles++;
            if (new_in) begin
                hwdata_v[d] = q[inflight].wdata;
                new_in = 1'b0;
                low_cnt = 0;
            end
            ro = hreadyout_v[d];
            rs = hresp_v[d];
            rd = hrdata_v[d];
            if (inflight >= 0) begin
                if (!ro) begin
                    low_cnt++;
                    checkOutput(tag(d, "stall_resp"), 32'(rs), 32'(isErr(q[inflight].addr)));
                    checkOutput(tag(d, "stall_rdata"), rd, 32'h0);
                end else begin
                    completeXfer(d, q[inflight], low_cnt, rs, rd);
                    inflight = -1;
                end
            end else begin
                checkOutput(tag(d, "idle_ready"), 32'(ro), 32'h1);
                checkOutput(tag(d, "idle_resp"), 32'(rs), 32'h0);
                checkOutput(tag(d, "idle_rdata"), rd, 32'h0);
            end
            if (ro) begin
                if (idx < q.size()) begin
                    driveAddr(d, q[idx]);
                    if (q[idx].sel && q[idx].trans[1]) begin
                        inflight = idx;
                        new_in = 1'b1;
                    end
                    idx++;
                end else begin
                    driveIdle(d);
                end
            end
        end
        if (idx < q.size() || inflight >= 0) begin
            checkOutput(tag(d, "timeout_left"), 32'(q.size() - idx + ((inflight >= 0) ? 1 : 0)), 32'h0);
        end
        driveIdle(d);
        q.delete();
    endtask

    // Async reset asserted while a write on the wait-state instance is still stalled.
    task automatic resetMidWrite(input int d, input bit [31:0] addr);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'd2; x.write = 1'b1;
        x.addr = addr; x.size = 3'd2; x.wdata = 32'h1234_5678;
        @(negedge hclk);
        driveAddr(d, x);
        @(negedge hclk);
        driveIdle(d);
        hwdata_v[d] = x.wdata;
        checkOutput(tag(d, "prereset_ready"), 32'(hreadyout_v[d]), 32'h0);
        #2 hreset_v[d] = 1'b1;
        #1;
        checkOutput(tag(d, "rst_ready"), 32'(hreadyout_v[d]), 32'h1);
        checkOutput(tag(d, "rst_resp"), 32'(hresp_v[d]), 32'h0);
        checkOutput(tag(d, "rst_rdata"), hrdata_v[d], 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[d][i] = 32'h0;
        end
        @(negedge hclk);
        hreset_v[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            hreset_v[d] = 1'b1;
            hwdata_v[d] = 32'h0;
            hburst_v[d] = 3'd0;
            hprot_v[d] = 4'd0;
            hmastlock_v[d] = 1'b0;
            driveIdle(d);
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[d][i] = 32'h0;
            end
        end
        repeat (2) @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            checkOutput(tag(d, "reset_ready"), 32'(hreadyout_v[d]), 32'h1);
            checkOutput(tag(d, "reset_resp"), 32'(hresp_v[d]), 32'h0);
            checkOutput(tag(d, "reset_rdata"), hrdata_v[d], 32'h0);
            hreset_v[d] = 1'b0;
        end

        for (int d = 0; d < 2; d++) begin
            $display("[TB] directed transfers on instance %0d", d);
            addXfer(1, 2, 1, 32'h24, 3'd2, 32'hDEAD_BEEF);
            addXfer(1, 2, 0, 32'h24, 3'd2, 32'h0);
            addXfer(1, 3, 0, 32'h04, 3'd2, 32'h0);
            applyStimulus(d);

            addXfer(1, 2, 1, 32'h08, 3'd2, 32'h1122_3344);
            addXfer(1, 2, 1, 32'h0A, 3'd0, 32'h00AA_0000);
            addXfer(1, 3, 1, 32'h08, 3'd1, 32'h0000_BBCC);
            addXfer(1, 2, 0, 32'h08, 3'd2, 32'h0);
            applyStimulus(d);

            addXfer(1, 0, 1, 32'h24, 3'd2, 32'h0BAD_0BAD);
            addXfer(0, 2, 1, 32'h24, 3'd2, 32'h0BAD_0BAD);
            addXfer(1, 1, 1, 32'h24, 3'd2, 32'h0BAD_0BAD);
            addXfer(1, 2, 0, 32'h24, 3'd2, 32'h0);
            applyStimulus(d);

            addXfer(1, 2, 1, 32'h40, 3'd2, 32'h55AA_55AA);
            addXfer(1, 2, 0, 32'h00, 3'd2, 32'h0);
            addXfer(1, 2, 0, 32'h40, 3'd2, 32'h0);
            applyStimulus(d);

            $display("[TB] random transfers on instance %0d", d);
            for (int n = 0; n < 3; n++) begin
                for (int k = 0; k < 40; k++) begin
                    addXfer(($urandom_range(0, 9) != 0),
                            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
                            1'($urandom),
                            ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 15)),
                            3'($urandom_range(0, 7)),
                            $urandom);
                end
                applyStimulus(d);
            end
        end

        $display("[TB] reset during stalled write");
        addXfer(1, 2, 1, 32'h10, 3'd2, 32'hCAFE_F00D);
        applyStimulus(1);
        resetMidWrite(1, 32'h10);
        addXfer(1, 2, 0, 32'h10, 3'd2, 32'h0);
        addXfer(1, 2, 0, 32'h24, 3'd2, 32'h0);
        applyStimulus(1);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
